bitboard_flood_shift: RTL and testbench

//  Iterative directional flood engine for SIDExSIDE bitboards; generalises the row-masked 64-bit shifter to 8 directions and any board side.

---
 rtl/bitboard_flood_shift_pkg.sv | 62 ++++++
 rtl/bitboard_flood_shift_if.sv | 31 +++
 rtl/bitboard_flood_shift_dir_shift.sv | 45 ++++
 rtl/bitboard_flood_shift.sv | 129 ++++++++++++
 tb/tb_bitboard_flood_shift.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/bitboard_flood_shift_pkg.sv
// Shared types and helpers for the directional bitboard flood engine.
// Bit index = row*SIDE + col; boards up to 32x32 are supported by col_mask.
package bitboard_flood_shift_pkg;

  localparam int SIDE_DEFAULT = 8;
  localparam int BITS         = SIDE_DEFAULT * SIDE_DEFAULT;
  localparam int MAX_BITS     = 1024;

  typedef enum logic [2:0] {
    DIR_E  = 3'd0,
    DIR_W  = 3'd1,
    DIR_N  = 3'd2,
    DIR_S  = 3'd3,
    DIR_NE = 3'd4,
    DIR_NW = 3'd5,
    DIR_SE = 3'd6,
    DIR_SW = 3'd7
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int dir_dx(input dir_t d);
    case (d)
      DIR_E, DIR_NE, DIR_SE: return 1;
      DIR_W, DIR_NW, DIR_SW: return -1;
      default:               return 0;
    endcase
  endfunction

  function automatic int dir_dy(input dir_t d);
    case (d)
      DIR_N, DIR_NE, DIR_NW: return 1;
      DIR_S, DIR_SE, DIR_SW: return -1;
      default:               return 0;
    endcase
  endfunction

  // Squares a dx-shift may legally land on: the column entered by wrap-around is cleared.
  function automatic logic [MAX_BITS-1:0] col_mask(input int side, input int dx);
    logic [MAX_BITS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BITS; i++) begin
      if (i < side * side) begin
        if (dx > 0) begin
          m[i] = ((i % side) != 0);
        end else if (dx < 0) begin
          m[i] = ((i % side) != (side - 1));
        end else begin
          m[i] = 1'b1;
        end
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/bitboard_flood_shift_if.sv
// Request/response bundle of the flood engine: one direction per request.
interface bitboard_flood_shift_if
  import bitboard_flood_shift_pkg::*;
#(
  parameter int SIDE      = 8,
  parameter int MAX_STEPS = SIDE - 2
);
  localparam int NBITS   = SIDE * SIDE;
  localparam int STEPS_W = $clog2(MAX_STEPS + 1);

  logic               in_valid;
  logic               in_ready;
  logic [NBITS-1:0]   in_seed;
  logic [NBITS-1:0]   in_prop;
  dir_t               in_dir;
  logic               out_valid;
  logic               out_ready;
  logic [NBITS-1:0]   out_flood;
  logic [NBITS-1:0]   out_edge;
  logic [STEPS_W-1:0] out_steps;

  modport master (
    output in_valid, in_seed, in_prop, in_dir, out_ready,
    input  in_ready, out_valid, out_flood, out_edge, out_steps
  );

  modport slave (
    input  in_valid, in_seed, in_prop, in_dir, out_ready,
    output in_ready, out_valid, out_flood, out_edge, out_steps
  );
endinterface

// File: rtl/bitboard_flood_shift_dir_shift.sv
// Combinational one-square shift of a SIDExSIDE bitboard in one of 8 directions;
// squares leaving the board are dropped, never wrapped onto the adjacent row.
module bitboard_dir_shift
  import bitboard_flood_shift_pkg::*;
#(
  parameter int SIDE = 8
) (
  input  logic [SIDE*SIDE-1:0] x,
  input  dir_t                 dir,
  output logic [SIDE*SIDE-1:0] y
);
  localparam int NBITS = SIDE * SIDE;
  localparam logic [MAX_BITS-1:0] MASK_E_FULL = col_mask(SIDE, 1);
  localparam logic [MAX_BITS-1:0] MASK_W_FULL = col_mask(SIDE, -1);
  localparam logic [NBITS-1:0]    MASK_E      = MASK_E_FULL[NBITS-1:0];
  localparam logic [NBITS-1:0]    MASK_W      = MASK_W_FULL[NBITS-1:0];

  logic [NBITS-1:0] shifted_s;
  logic [NBITS-1:0] mask_s;

  // Row moves are whole-SIDE index shifts; column moves need the wrap mask.
  always_comb begin
    shifted_s = '0;
    case (dir)
      DIR_E:   shifted_s = x << 1;
      DIR_W:   shifted_s = x >> 1;
      DIR_N:   shifted_s = x << SIDE;
      DIR_S:   shifted_s = x >> SIDE;
      DIR_NE:  shifted_s = x << (SIDE + 1);
      DIR_NW:  shifted_s = x << (SIDE - 1);
      DIR_SE:  shifted_s = x >> (SIDE - 1);
      DIR_SW:  shifted_s = x >> (SIDE + 1);
      default: shifted_s = '0;
    endcase
    if (dir_dx(dir) > 0) begin
      mask_s = MASK_E;
    end else if (dir_dx(dir) < 0) begin
      mask_s = MASK_W;
    end else begin
      mask_s = '1;
    end
    y = shifted_s & mask_s;
  end

endmodule

// File: rtl/bitboard_flood_shift.sv
// Iterative directional flood: steps a frontier from the seed through the
// propagation mask, accumulating the flooded set and the square past each chain end.
module bitboard_flood_shift
  import bitboard_flood_shift_pkg::*;
#(
  parameter int SIDE      = 8,
  parameter int MAX_STEPS = SIDE - 2
) (
  input logic                  clk,
  input logic                  rst_n,
  bitboard_flood_shift_if.slave bus
);
  localparam int NBITS   = SIDE * SIDE;
  localparam int STEPS_W = $clog2(MAX_STEPS + 1);

  state_t             state_r;
  logic [NBITS-1:0]   f_r;
  logic [NBITS-1:0]   acc_r;
  logic [STEPS_W-1:0] cnt_r;
  dir_t               dir_r;
  logic [NBITS-1:0]   prop_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [NBITS-1:0]   out_flood_r;
  logic [NBITS-1:0]   out_edge_r;
  logic [STEPS_W-1:0] out_steps_r;

  logic [NBITS-1:0]   shift_in_s;
  dir_t               shift_dir_s;
  logic [NBITS-1:0]   gate_s;
  logic [NBITS-1:0]   shifted_s;
  logic [NBITS-1:0]   step_s;
  logic [NBITS-1:0]   acc_shifted_s;
  logic [NBITS-1:0]   edge_s;

  // In IDLE the shared shifter computes the first frontier straight from the request.
  always_comb begin
    if (state_r == ST_IDLE) begin
      shift_in_s  = bus.in_seed;
      shift_dir_s = bus.in_dir;
      gate_s      = bus.in_prop;
    end else begin
      shift_in_s  = f_r;
      shift_dir_s = dir_r;
      gate_s      = prop_r;
    end
    step_s = shifted_s & gate_s;
    edge_s = acc_shifted_s & ~prop_r;
  end

  bitboard_dir_shift #(.SIDE(SIDE)) u_step_shift (
    .x   (shift_in_s),
    .dir (shift_dir_s),
    .y   (shifted_s)
  );

  bitboard_dir_shift #(.SIDE(SIDE)) u_edge_shift (
    .x   (acc_r),
    .dir (dir_r),
    .y   (acc_shifted_s)
  );

  // Control FSM together with datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      f_r         <= '0;
      acc_r       <= '0;
      cnt_r       <= '0;
      dir_r       <= DIR_E;
      prop_r      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_flood_r <= '0;
      out_edge_r  <= '0;
      out_steps_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            f_r        <= step_s;
            acc_r      <= step_s;
            cnt_r      <= STEPS_W'(1);
            dir_r      <= bus.in_dir;
            prop_r     <= bus.in_prop;
            in_ready_r <= 1'b0;
            state_r    <= ST_BUSY;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ST_BUSY: begin
          if ((f_r == '0) || (cnt_r == STEPS_W'(MAX_STEPS))) begin
            out_flood_r <= acc_r;
            out_edge_r  <= edge_s;
            out_steps_r <= cnt_r;
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            f_r   <= step_s;
            acc_r <= acc_r | step_s;
            cnt_r <= cnt_r + STEPS_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_flood = out_flood_r;
  assign bus.out_edge  = out_edge_r;
  assign bus.out_steps = out_steps_r;

endmodule

// File: tb/tb_bitboard_flood_shift.sv
// Self-checking bench for bitboard_flood_shift (SIDE=8, MAX_STEPS=6): directed
// vector table, backpressure and reset corner cases, and random requests vs. a coordinate model.
module tb_bitboard_flood_shift;
  import bitboard_flood_shift_pkg::*;

  localparam int SIDE      = 8;
  localparam int MAX_STEPS = 6;
  localparam int DX[8] = '{1, -1, 0, 0, 1, -1, 1, -1};
  localparam int DY[8] = '{0, 0, 1, -1, 1, 1, -1, -1};
  localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bitboard_flood_shift_if #(.SIDE(SIDE), .MAX_STEPS(MAX_STEPS)) bus ();

  bitboard_flood_shift #(.SIDE(SIDE), .MAX_STEPS(MAX_STEPS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] seed;
    logic [63:0] prop;
    int          dir;
    logic [63:0] flood;
    logic [63:0] edge_b;
    int          steps;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Move every set square by (dx,dy) on the row/column grid, discarding off-board squares.
  function automatic logic [63:0] mshift(input logic [63:0] x, input int d);
    logic [63:0] y;
    int nr;
    int nc;
    y = '0;
    for (int r = 0; r < SIDE; r++) begin
      for (int c = 0; c < SIDE; c++) begin
        if (x[r*SIDE+c]) begin
          nr = r + DY[d];
          nc = c + DX[d];
          if (nr >= 0 && nr < SIDE && nc >= 0 && nc < SIDE) y[nr*SIDE+nc] = 1'b1;
        end
      end
    end
    return y;
  endfunction

  task automatic model(input logic [63:0] seed, input logic [63:0] prop, input int d,
                       output logic [63:0] flood, output logic [63:0] edge_b, output int steps);
    logic [63:0] f;
    f = mshift(seed, d) & prop;
    flood = f;
    steps = 1;
    while (f != 64'd0 && steps < MAX_STEPS) begin
      f = mshift(f, d) & prop;
      flood = flood | f;
      steps++;
    end
    edge_b = mshift(flood, d) & ~prop;
  endtask

  task automatic run_txn(input string name, input logic [63:0] seed, input logic [63:0] prop,
                         input int d, input logic [63:0] ef, input logic [63:0] ee,
                         input int es, input int hold);
    int lat;
    @(negedge clk);
    chk({name, " in_ready idle"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.in_seed   = seed;
    bus.in_prop   = prop;
    bus.in_dir    = dir_t'(3'(d));
    bus.out_ready = 1'b0;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_seed  = {$urandom, $urandom};
      bus.in_prop  = {$urandom, $urandom};
      bus.in_dir   = dir_t'(3'($urandom_range(7)));
      lat++;
    end while (!bus.out_valid && lat < 20);
    chk({name, " latency"}, 64'(lat), 64'(1 + es));
    chk({name, " flood"}, bus.out_flood, ef);
    chk({name, " edge"}, bus.out_edge, ee);
    chk({name, " steps"}, 64'(bus.out_steps), 64'(es));
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'(h % 2);
      bus.in_seed  = {$urandom, $urandom};
      @(negedge clk);
      chk({name, " hold valid"}, 64'(bus.out_valid), 64'd1);
      chk({name, " hold in_ready"}, 64'(bus.in_ready), 64'd0);
      chk({name, " hold flood"}, bus.out_flood, ef);
      chk({name, " hold steps"}, 64'(bus.out_steps), 64'(es));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({name, " consumed valid"}, 64'(bus.out_valid), 64'd0);
    chk({name, " consumed in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] s;
    logic [63:0] p;
    logic [63:0] ef;
    logic [63:0] ee;
    int          d;
    int          es;

    vecs[0] = '{64'h1, 64'h0E, 0, 64'h0E, 64'h10, 4};
    vecs[1] = '{64'h80, ALL, 0, 64'h0, 64'h0, 1};
    vecs[2] = '{64'h1, ALL, 2, 64'h0001_0101_0101_0100, 64'h0, 6};
    vecs[3] = '{64'h40, ALL, 4, 64'h8000, 64'h0, 2};
    vecs[4] = '{64'h100, ALL, 1, 64'h0, 64'h0, 1};
    vecs[5] = '{64'h1, ALL, 3, 64'h0, 64'h0, 1};
    vecs[6] = '{64'h8000_0000_0000_0000, ALL, 7, 64'h0040_2010_0804_0200, 64'h0, 6};
    vecs[7] = '{64'h8, 64'h0008_0800, 2, 64'h0008_0800, 64'h0800_0000, 3};

    bus.in_valid  = 1'b0;
    bus.in_seed   = '0;
    bus.in_prop   = '0;
    bus.in_dir    = DIR_E;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset flood", bus.out_flood, 64'd0);
    chk("reset edge", bus.out_edge, 64'd0);
    chk("reset steps", 64'(bus.out_steps), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].seed, vecs[i].prop, vecs[i].dir,
              vecs[i].flood, vecs[i].edge_b, vecs[i].steps, 0);
    end

    run_txn("backpressure", vecs[0].seed, vecs[0].prop, vecs[0].dir,
            vecs[0].flood, vecs[0].edge_b, vecs[0].steps, 5);
    repeat (3) @(negedge clk);
    chk("no stray accept", 64'(bus.out_valid), 64'd0);

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_seed  = 64'h1;
    bus.in_prop  = ALL;
    bus.in_dir   = DIR_N;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", 64'(bus.out_valid), 64'd0);
    chk("midreset in_ready", 64'(bus.in_ready), 64'd1);
    chk("midreset flood", bus.out_flood, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn("after reset", vecs[0].seed, vecs[0].prop, vecs[0].dir,
            vecs[0].flood, vecs[0].edge_b, vecs[0].steps, 0);

    for (int i = 0; i < 60; i++) begin
      if (i % 3 == 0) begin
        s = 64'd1 << $urandom_range(63);
      end else begin
        s = {$urandom, $urandom} & {$urandom, $urandom};
      end
      if (i % 2 == 0) begin
        p = ~(64'd1 << $urandom_range(63));
      end else begin
        p = {$urandom, $urandom} | {$urandom, $urandom};
      end
      d = $urandom_range(7);
      model(s, p, d, ef, ee, es);
      run_txn($sformatf("rand%0d", i), s, p, d, ef, ee, es, $urandom_range(3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
